// File: rtl/mem_bus_pkg.sv
// Shared memory-bus types and widths for the cpu/secondary bus arbiters.
package mem_bus_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_STRB_W = 4;

   typedef struct packed {
      logic [MEM_STRB_W-1:0] wstrb;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant to the first valid requester at or after ptr.
module rr_pick #(
   parameter  int N  = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   // Scan N positions starting at ptr, wrapping, and keep only the first hit.
   always_comb begin
      logic found;
      int   idx;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory bus arbiter: cpu always wins and is forwarded combinationally;
// secondaries share the cpu's idle cycles round-robin and get a 1-cycle response pulse.
module mem_port_arbiter
   import mem_bus_pkg::*;
#(
   parameter int NREQ         = 2,
   parameter int STARVE_LIMIT = 64
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   cpu_enable_i,
   input  logic [MEM_STRB_W-1:0]  cpu_wstrb_i,
   input  logic [MEM_ADDR_W-1:0]  cpu_addr_i,
   input  logic [MEM_DATA_W-1:0]  cpu_wvalue_i,
   output logic [MEM_DATA_W-1:0]  cpu_rvalue_o,
   input  logic [NREQ-1:0]        req_valid_i,
   output logic [NREQ-1:0]        req_ready_o,
   input  logic [NREQ*4-1:0]      req_wstrb_i,
   input  logic [NREQ*32-1:0]     req_addr_i,
   input  logic [NREQ*32-1:0]     req_wdata_i,
   output logic [NREQ-1:0]        rsp_valid_o,
   output logic [MEM_DATA_W-1:0]  rsp_rdata_o,
   output logic                   mem_enable_o,
   output logic [MEM_STRB_W-1:0]  mem_wstrb_o,
   output logic [MEM_ADDR_W-1:0]  mem_addr_o,
   output logic [MEM_DATA_W-1:0]  mem_wvalue_o,
   input  logic [MEM_DATA_W-1:0]  mem_rvalue_i,
   output logic [NREQ-1:0]        starve_o,
   output logic [15:0]            wait_cnt_o
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   ptr_nxt;
   logic [NREQ-1:0] pick;
   logic [NREQ-1:0] grant;
   logic [NREQ-1:0] rsp_owner;
   logic [CW-1:0]   wcnt [NREQ];
   mem_req_t        sel_req;

   rr_pick #(.N(NREQ)) u_rr_pick (
      .valid (req_valid_i),
      .ptr   (rr_ptr),
      .grant (pick)
   );

   // The cpu has no stall, so any cpu cycle masks every secondary grant.
   assign grant        = cpu_enable_i ? '0 : pick;
   assign req_ready_o  = grant;
   assign rsp_valid_o  = rsp_owner;
   assign cpu_rvalue_o = mem_rvalue_i;
   assign rsp_rdata_o  = mem_rvalue_i;

   // Winner index and its payload, picked from the packed request buses.
   always_comb begin
      win_idx = '0;
      sel_req = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick[i]) begin
            win_idx       = PW'(i);
            sel_req.wstrb = req_wstrb_i[i*4 +: 4];
            sel_req.addr  = req_addr_i[i*32 +: 32];
            sel_req.wdata = req_wdata_i[i*32 +: 32];
         end
      end
      ptr_nxt = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
   end

   // Bus mux: cpu overrides, then the round-robin winner, else an idle (all-zero) bus.
   always_comb begin
      mem_enable_o = 1'b0;
      mem_wstrb_o  = '0;
      mem_addr_o   = '0;
      mem_wvalue_o = '0;
      if (cpu_enable_i) begin
         mem_enable_o = 1'b1;
         mem_wstrb_o  = cpu_wstrb_i;
         mem_addr_o   = cpu_addr_i;
         mem_wvalue_o = cpu_wvalue_i;
      end else if (|req_valid_i) begin
         mem_enable_o = 1'b1;
         mem_wstrb_o  = sel_req.wstrb;
         mem_addr_o   = sel_req.addr;
         mem_wvalue_o = sel_req.wdata;
      end
   end

   // Rotate the pointer past each secondary winner and remember who owns the response.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rr_ptr    <= '0;
         rsp_owner <= '0;
      end else begin
         if (|grant) rr_ptr <= ptr_nxt;
         rsp_owner <= grant;
      end
   end

   // Per-port consecutive-wait counters; starve flag sticks once a counter hits the limit.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         starve_o <= '0;
         for (int i = 0; i < NREQ; i++) wcnt[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid_i[i] && !grant[i]) begin
               if (wcnt[i] != CW'(STARVE_LIMIT)) wcnt[i] <= wcnt[i] + CW'(1);
               if (wcnt[i] == CW'(STARVE_LIMIT - 1)) starve_o[i] <= 1'b1;
            end else begin
               wcnt[i] <= '0;
            end
         end
      end
   end

   // Saturating count of cycles where the cpu blocked at least one waiting secondary.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wait_cnt_o <= '0;
      end else if (cpu_enable_i && (|req_valid_i) && (wait_cnt_o != 16'hFFFF)) begin
         wait_cnt_o <= wait_cnt_o + 16'd1;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (NREQ=2, STARVE_LIMIT=4).
module tb_mem_port_arbiter;

   localparam int NREQ = 2;
   localparam int SL   = 4;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        cpu_enable_i;
   logic [3:0]  cpu_wstrb_i;
   logic [31:0] cpu_addr_i;
   logic [31:0] cpu_wvalue_i;
   logic [31:0] cpu_rvalue_o;
   logic [1:0]  req_valid_i;
   logic [1:0]  req_ready_o;
   logic [7:0]  req_wstrb_i;
   logic [63:0] req_addr_i;
   logic [63:0] req_wdata_i;
   logic [1:0]  rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        mem_enable_o;
   logic [3:0]  mem_wstrb_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wvalue_o;
   logic [31:0] mem_rvalue_i;
   logic [1:0]  starve_o;
   logic [15:0] wait_cnt_o;

   int total = 0;
   int bad   = 0;

   mem_port_arbiter #(.NREQ(NREQ), .STARVE_LIMIT(SL)) dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .cpu_enable_i (cpu_enable_i),
      .cpu_wstrb_i  (cpu_wstrb_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_wvalue_i (cpu_wvalue_i),
      .cpu_rvalue_o (cpu_rvalue_o),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_wstrb_i  (req_wstrb_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_rdata_o  (rsp_rdata_o),
      .mem_enable_o (mem_enable_o),
      .mem_wstrb_o  (mem_wstrb_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wvalue_o (mem_wvalue_o),
      .mem_rvalue_i (mem_rvalue_i),
      .starve_o     (starve_o),
      .wait_cnt_o   (wait_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        cpu_en;
      logic [3:0]  cpu_wstrb;
      logic [31:0] cpu_addr;
      logic [31:0] cpu_wdata;
      logic [1:0]  valid;
      logic [1:0]  exp_ready;
      logic        exp_en;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [1:0]  exp_rsp;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      cpu_enable_i = 1'b0;
      cpu_wstrb_i  = '0;
      cpu_addr_i   = '0;
      cpu_wvalue_i = '0;
      req_valid_i  = '0;
      @(posedge clk_i);
      #1;
      rstn_i = 1'b0;
      #2;
      rstn_i = 1'b1;
   endtask

   initial begin
      logic [1:0] exp_g;
      logic [1:0] prev_g;
      int         ptr;

      // port 0: read of 0x100; port 1: full-word write of 0xB1 to 0x200
      req_wstrb_i  = {4'b1111, 4'b0000};
      req_addr_i   = {32'h0000_0200, 32'h0000_0100};
      req_wdata_i  = {32'h0000_00B1, 32'h0000_00A0};
      mem_rvalue_i = 32'h0;
      rstn_i       = 1'b1;

      //          cpu  strb     addr   wdata  valid rdy  en  strb     addr   wdata  rsp
      vecs[0]  = '{0, 4'b0000, 32'h0,  32'h0,  2'b00, 2'b00, 0, 4'b0000, 32'h0,   32'h0,  2'b00};
      vecs[1]  = '{1, 4'b0000, 32'h10, 32'h11, 2'b00, 2'b00, 1, 4'b0000, 32'h10,  32'h11, 2'b00};
      vecs[2]  = '{1, 4'b0011, 32'h14, 32'h22, 2'b01, 2'b00, 1, 4'b0011, 32'h14,  32'h22, 2'b00};
      vecs[3]  = '{0, 4'b0000, 32'h0,  32'h0,  2'b01, 2'b01, 1, 4'b0000, 32'h100, 32'hA0, 2'b00};
      vecs[4]  = '{0, 4'b0000, 32'h0,  32'h0,  2'b11, 2'b10, 1, 4'b1111, 32'h200, 32'hB1, 2'b01};
      vecs[5]  = '{0, 4'b0000, 32'h0,  32'h0,  2'b11, 2'b01, 1, 4'b0000, 32'h100, 32'hA0, 2'b10};
      vecs[6]  = '{0, 4'b0000, 32'h0,  32'h0,  2'b01, 2'b01, 1, 4'b0000, 32'h100, 32'hA0, 2'b01};
      vecs[7]  = '{1, 4'b0101, 32'h20, 32'h33, 2'b11, 2'b00, 1, 4'b0101, 32'h20,  32'h33, 2'b01};
      vecs[8]  = '{0, 4'b0000, 32'h0,  32'h0,  2'b10, 2'b10, 1, 4'b1111, 32'h200, 32'hB1, 2'b00};
      vecs[9]  = '{0, 4'b0000, 32'h0,  32'h0,  2'b00, 2'b00, 0, 4'b0000, 32'h0,   32'h0,  2'b10};
      vecs[10] = '{0, 4'b0000, 32'h0,  32'h0,  2'b00, 2'b00, 0, 4'b0000, 32'h0,   32'h0,  2'b00};

      do_reset();
      chk("reset_rsp", 32'(rsp_valid_o), 32'h0);
      chk("reset_starve", 32'(starve_o), 32'h0);
      chk("reset_wait_cnt", 32'(wait_cnt_o), 32'h0);

      // table: bus mux, ready, round-robin order and response owner
      for (int i = 0; i < 11; i++) begin
         cpu_enable_i = vecs[i].cpu_en;
         cpu_wstrb_i  = vecs[i].cpu_wstrb;
         cpu_addr_i   = vecs[i].cpu_addr;
         cpu_wvalue_i = vecs[i].cpu_wdata;
         req_valid_i  = vecs[i].valid;
         #1;
         chk($sformatf("v%0d_ready", i), 32'(req_ready_o), 32'(vecs[i].exp_ready));
         chk($sformatf("v%0d_en", i), 32'(mem_enable_o), 32'(vecs[i].exp_en));
         chk($sformatf("v%0d_wstrb", i), 32'(mem_wstrb_o), 32'(vecs[i].exp_wstrb));
         chk($sformatf("v%0d_addr", i), mem_addr_o, vecs[i].exp_addr);
         chk($sformatf("v%0d_wdata", i), mem_wvalue_o, vecs[i].exp_wdata);
         chk($sformatf("v%0d_rsp", i), 32'(rsp_valid_o), 32'(vecs[i].exp_rsp));
         step();
      end
      chk("table_wait_cnt", 32'(wait_cnt_o), 32'd2);
      chk("table_starve", 32'(starve_o), 32'h0);

      // reset right after a req0 read grant drops the response
      cpu_enable_i = 1'b0;
      req_valid_i  = 2'b01;
      #1;
      chk("rst_grant_ready", 32'(req_ready_o), 32'h1);
      @(posedge clk_i);
      #1;
      req_valid_i = 2'b00;
      rstn_i      = 1'b0;
      #1;
      chk("rst_mid_rsp", 32'(rsp_valid_o), 32'h0);
      chk("rst_mid_starve", 32'(starve_o), 32'h0);
      chk("rst_mid_wait_cnt", 32'(wait_cnt_o), 32'h0);
      rstn_i = 1'b1;
      step();
      chk("rst_after_rsp", 32'(rsp_valid_o), 32'h0);

      // cpu only read
      cpu_enable_i = 1'b1;
      cpu_addr_i   = 32'h10;
      cpu_wstrb_i  = 4'b0000;
      #1;
      chk("cpu_addr", mem_addr_o, 32'h10);
      chk("cpu_en", 32'(mem_enable_o), 32'h1);
      step();
      cpu_enable_i = 1'b0;
      mem_rvalue_i = 32'hDEADBEEF;
      #1;
      chk("cpu_rvalue", cpu_rvalue_o, 32'hDEADBEEF);
      chk("cpu_rsp_rdata", rsp_rdata_o, 32'hDEADBEEF);
      chk("cpu_no_rsp", 32'(rsp_valid_o), 32'h0);
      step();

      // cpu / secondary conflict
      cpu_enable_i = 1'b1;
      req_valid_i  = 2'b01;
      #1;
      chk("conf_ready_blocked", 32'(req_ready_o), 32'h0);
      step();
      chk("conf_wait_cnt", 32'(wait_cnt_o), 32'd1);
      cpu_enable_i = 1'b0;
      #1;
      chk("conf_ready_free", 32'(req_ready_o), 32'h1);
      step();
      req_valid_i = 2'b00;
      #1;
      chk("conf_rsp", 32'(rsp_valid_o), 32'h1);
      step();
      chk("conf_rsp_end", 32'(rsp_valid_o), 32'h0);

      // fairness with both secondaries valid
      do_reset();
      req_valid_i = 2'b11;
      ptr    = 0;
      prev_g = 2'b00;
      for (int c = 0; c < 4; c++) begin
         exp_g = (ptr == 0) ? 2'b01 : 2'b10;
         #1;
         chk($sformatf("fair%0d_ready", c), 32'(req_ready_o), 32'(exp_g));
         chk($sformatf("fair%0d_rsp", c), 32'(rsp_valid_o), 32'(prev_g));
         prev_g = exp_g;
         ptr    = 1 - ptr;
         step();
      end
      req_valid_i = 2'b00;
      #1;
      chk("fair_last_rsp", 32'(rsp_valid_o), 32'(prev_g));
      step();

      // starvation of port 1 behind the cpu
      do_reset();
      cpu_enable_i = 1'b1;
      req_valid_i  = 2'b10;
      for (int c = 1; c <= 5; c++) begin
         step();
         chk($sformatf("starve_c%0d", c), 32'(starve_o), (c >= SL) ? 32'h2 : 32'h0);
      end
      cpu_enable_i = 1'b0;
      #1;
      chk("starve_grant", 32'(req_ready_o), 32'h2);
      step();
      req_valid_i = 2'b00;
      step();
      chk("starve_sticky", 32'(starve_o), 32'h2);
      chk("starve_wait_cnt", 32'(wait_cnt_o), 32'd5);

      // wait_cnt saturation
      do_reset();
      cpu_enable_i = 1'b1;
      req_valid_i  = 2'b01;
      repeat (65534) step();
      chk("sat_fffe", 32'(wait_cnt_o), 32'h0000FFFE);
      step();
      chk("sat_ffff", 32'(wait_cnt_o), 32'h0000FFFF);
      repeat (70000 - 65535) step();
      chk("sat_nowrap", 32'(wait_cnt_o), 32'h0000FFFF);
      chk("sat_starve0", 32'(starve_o), 32'h1);
      cpu_enable_i = 1'b0;
      req_valid_i  = 2'b00;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
